// File: rtl/bmp_pkg.sv
// Shared types and helpers for the BMP frame loader.
// Frame defaults match the 640x480 24-bit BMP file layout.
package bmp_pkg;

  typedef enum logic [1:0] {
    HEADER,
    PIXEL,
    DONE
  } bmp_state_t;

  localparam int DEF_FRAME_W      = 640;
  localparam int DEF_FRAME_H      = 480;
  localparam int DEF_HEADER_BYTES = 54;

  function automatic logic [15:0] rgb888_to_565(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/bmp_frame_loader_if.sv
// Byte-in / pixel-write bundle between SD reader, loader and frame buffer.
// master = byte source side, slave = loader side.
interface bmp_frame_loader_if #(
  parameter int ADDR_W = 19
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (
    output in_valid, in_byte,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_byte,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/bmp_frame_loader.sv
// Skips the BMP header, packs BGR triplets to RGB565 and writes them
// top-down into a linear frame buffer.
module bmp_frame_loader
  import bmp_pkg::*;
#(
  parameter int HEADER_BYTES = DEF_HEADER_BYTES,
  parameter int FRAME_W      = DEF_FRAME_W,
  parameter int FRAME_H      = DEF_FRAME_H,
  parameter int ADDR_W       = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  bmp_frame_loader_if.slave bus,
  output logic frame_done,
  output logic overflow
);

  localparam int HW = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;
  localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  localparam logic [HW-1:0] HDR_LAST = HW'(HEADER_BYTES - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(FRAME_W - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'((FRAME_H - 1) * FRAME_W);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FRAME_W);
  localparam bmp_state_t START = (HEADER_BYTES == 0) ? PIXEL : HEADER;

  bmp_state_t        state, state_d;
  logic [HW-1:0]     hdr_cnt;
  logic [1:0]        phase;
  logic [7:0]        b_q, g_q;
  logic [XW-1:0]     x;
  logic [ADDR_W-1:0] row_base;

  logic pix_r, last_pix, x_last;

  assign x_last   = (x == X_LAST);
  assign last_pix = (row_base == '0) && x_last;
  assign pix_r    = (state == PIXEL) && bus.in_valid && (phase == 2'd2);

  always_comb begin
    state_d = state;
    case (state)
      HEADER:
        if (bus.in_valid && hdr_cnt == HDR_LAST)
          state_d = PIXEL;
      PIXEL:
        if (pix_r && last_pix)
          state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = START;
    endcase
    if (clear)
      state_d = START;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= START;
    else
      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt     <= '0;
      phase       <= '0;
      b_q         <= '0;
      g_q         <= '0;
      x           <= '0;
      row_base    <= ROW_LAST;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else if (clear) begin
      hdr_cnt    <= '0;
      phase      <= '0;
      x          <= '0;
      row_base   <= ROW_LAST;
      bus.wr_en  <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        HEADER:
          if (bus.in_valid)
            hdr_cnt <= hdr_cnt + 1'b1;
        PIXEL:
          if (bus.in_valid) begin
            case (phase)
              2'd0: begin
                b_q   <= bus.in_byte;
                phase <= 2'd1;
              end
              2'd1: begin
                g_q   <= bus.in_byte;
                phase <= 2'd2;
              end
              default: begin
                phase       <= 2'd0;
                bus.wr_en   <= 1'b1;
                bus.wr_addr <= row_base + ADDR_W'(x);
                bus.wr_data <= rgb888_to_565(bus.in_byte, g_q, b_q);
                // Bottom-up file rows land top-down: step back one row.
                if (x_last) begin
                  x        <= '0;
                  row_base <= row_base - ROW_STEP;
                end else begin
                  x <= x + 1'b1;
                end
                if (last_pix)
                  frame_done <= 1'b1;
              end
            endcase
          end
        DONE:
          if (bus.in_valid)
            overflow <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
